// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, datapath select encodings and FSM state codes
// for the multicycle MIPS controller.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_LUI   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;
  localparam logic [2:0] M2R_ALUOUT = 3'b000;
  localparam logic [2:0] M2R_MDR    = 3'b001;
  localparam logic [2:0] M2R_PC     = 3'b010;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP, S_JREG
  } state_t;
  typedef enum logic [2:0] {
    CL_MEM, CL_R, CL_I, CL_BRANCH, CL_JUMP, CL_JREG, CL_ILLEGAL
  } iclass_t;
endpackage

// File: rtl/opcode_class.sv
// opcode_class: maps opcode/funct to an instruction class plus the I-type ALUOp and ImmSrc.
module opcode_class
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] cls,
  output logic [3:0] i_aluop,
  output logic       i_immsrc
);
  always_comb begin
    cls = CL_ILLEGAL;
    i_aluop = ALU_ADD;
    i_immsrc = 1'b0;
    case (opcode)
      OP_RTYPE:       cls = (funct == FN_JR) ? CL_JREG : CL_R;
      OP_LW, OP_SW:   cls = CL_MEM;
      OP_BEQ, OP_BNE: cls = CL_BRANCH;
      OP_J, OP_JAL:   cls = CL_JUMP;
      OP_ADDI:        cls = CL_I;
      OP_ANDI:  begin cls = CL_I; i_aluop = ALU_AND;  i_immsrc = 1'b1; end
      OP_ORI:   begin cls = CL_I; i_aluop = ALU_OR;   i_immsrc = 1'b1; end
      OP_XORI:  begin cls = CL_I; i_aluop = ALU_XOR;  i_immsrc = 1'b1; end
      OP_SLTI:  begin cls = CL_I; i_aluop = ALU_SLT;  end
      OP_SLTIU: begin cls = CL_I; i_aluop = ALU_SLTU; end
      OP_LUI:   begin cls = CL_I; i_aluop = ALU_LUI;  end
      default:        cls = CL_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing fetch/decode/execute/memory/write-back for the
// multicycle MIPS datapath; all outputs are forced low while reset is high.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int RESET_PC_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [2:0] MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       ImmSrc,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t st, nst;
  logic [2:0] cls;
  logic [3:0] i_aluop;
  logic i_immsrc;
  logic [1:0] regdst_q;
  logic first_fetch;
  logic hold;
  opcode_class u_cls (
    .opcode(opcode),
    .funct(funct),
    .cls(cls),
    .i_aluop(i_aluop),
    .i_immsrc(i_immsrc)
  );
  assign hold = (RESET_PC_HOLD != 0) && first_fetch;
  assign state = reset ? S_FETCH : st;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_FETCH;
      regdst_q <= RD_RT;
      first_fetch <= 1'b1;
    end else begin
      st <= nst;
      if (st == S_EXEC_R) regdst_q <= RD_RD;
      else if (st == S_EXEC_I) regdst_q <= RD_RT;
      if (st == S_FETCH && mem_ready) first_fetch <= 1'b0;
    end
  end
  always_comb begin
    nst = S_FETCH;
    case (st)
      S_FETCH:    nst = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   nst = (cls == CL_MEM)    ? S_MEM_ADDR :
                        (cls == CL_R)      ? S_EXEC_R :
                        (cls == CL_I)      ? S_EXEC_I :
                        (cls == CL_BRANCH) ? S_BRANCH :
                        (cls == CL_JUMP)   ? S_JUMP :
                        (cls == CL_JREG)   ? S_JREG : S_FETCH;
      S_MEM_ADDR: nst = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nst = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nst = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R, S_EXEC_I: nst = S_ALU_WB;
      default:    nst = S_FETCH;
    endcase
  end
  always_comb begin
    PCWrite = 1'b0;
    PCSrc = PC_ALU;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegDst = RD_RT;
    MemToReg = M2R_ALUOUT;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_B;
    ALUOp = ALU_ADD;
    ImmSrc = 1'b0;
    illegal_op = 1'b0;
    if (!reset)
      case (st)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready && !hold;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM4;
          illegal_op = (cls == CL_ILLEGAL);
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemToReg = M2R_MDR;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp = ALU_FUNCT;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp = i_aluop;
          ImmSrc = i_immsrc;
        end
        S_ALU_WB: begin
          RegWrite = 1'b1;
          RegDst = regdst_q;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp = ALU_SUB;
          PCSrc = PC_ALUOUT;
          PCWrite = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc = PC_JUMP;
          RegWrite = (opcode == OP_JAL);
          RegDst = (opcode == OP_JAL) ? RD_RA : RD_RT;
          MemToReg = (opcode == OP_JAL) ? M2R_PC : M2R_ALUOUT;
        end
        S_JREG: begin
          PCWrite = 1'b1;
          PCSrc = PC_RS;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle scoreboard of expected control vectors, drained
// against the live DUT outputs, plus a RESET_PC_HOLD=1 instance for the boot hold.
module tb_multicycle_control;
  typedef struct packed {
    logic [3:0] st;
    logic pcw;
    logic [1:0] pcsrc;
    logic iord, mr, mw, irw;
    logic [1:0] regdst;
    logic [2:0] m2r;
    logic rw, asa;
    logic [1:0] asb;
    logic [3:0] aluop;
    logic imm, ill;
  } ov_t;
  typedef struct {
    string tag;
    logic rdy, z, rst;
    ov_t v;
  } ent_t;
  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ImmSrc, illegal_op;
  logic [1:0] PCSrc, RegDst, ALUSrcB;
  logic [2:0] MemToReg;
  logic [3:0] ALUOp, state;
  logic h_PCWrite, h_IorD, h_MemRead, h_MemWrite, h_IRWrite, h_RegWrite, h_ALUSrcA, h_ImmSrc, h_illegal_op;
  logic [1:0] h_PCSrc, h_RegDst, h_ALUSrcB;
  logic [2:0] h_MemToReg;
  logic [3:0] h_ALUOp, h_state;
  ov_t dv, hv;
  ent_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .illegal_op(illegal_op), .state(state)
  );
  multicycle_control #(.RESET_PC_HOLD(1)) hdut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(h_PCWrite), .PCSrc(h_PCSrc), .IorD(h_IorD), .MemRead(h_MemRead), .MemWrite(h_MemWrite),
    .IRWrite(h_IRWrite), .RegDst(h_RegDst), .MemToReg(h_MemToReg), .RegWrite(h_RegWrite),
    .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB), .ALUOp(h_ALUOp), .ImmSrc(h_ImmSrc),
    .illegal_op(h_illegal_op), .state(h_state)
  );
  assign dv = {state, PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op};
  assign hv = {h_state, h_PCWrite, h_PCSrc, h_IorD, h_MemRead, h_MemWrite, h_IRWrite, h_RegDst, h_MemToReg,
               h_RegWrite, h_ALUSrcA, h_ALUSrcB, h_ALUOp, h_ImmSrc, h_illegal_op};

  function automatic ov_t f_fetch(input logic rdy);
    ov_t o = '0;
    o.mr = 1'b1; o.asb = 2'b01; o.pcw = rdy; o.irw = rdy;
    return o;
  endfunction
  function automatic ov_t f_decode(input logic ill);
    ov_t o = '0;
    o.st = 4'd1; o.asb = 2'b11; o.ill = ill;
    return o;
  endfunction
  function automatic ov_t f_memaddr();
    ov_t o = '0;
    o.st = 4'd2; o.asa = 1'b1; o.asb = 2'b10;
    return o;
  endfunction
  function automatic ov_t f_memrd();
    ov_t o = '0;
    o.st = 4'd3; o.mr = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic ov_t f_memwb();
    ov_t o = '0;
    o.st = 4'd4; o.rw = 1'b1; o.m2r = 3'b001;
    return o;
  endfunction
  function automatic ov_t f_memwr();
    ov_t o = '0;
    o.st = 4'd5; o.mw = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic ov_t f_execr();
    ov_t o = '0;
    o.st = 4'd6; o.asa = 1'b1; o.aluop = 4'b0010;
    return o;
  endfunction
  function automatic ov_t f_execi(input logic [3:0] op, input logic imm);
    ov_t o = '0;
    o.st = 4'd7; o.asa = 1'b1; o.asb = 2'b10; o.aluop = op; o.imm = imm;
    return o;
  endfunction
  function automatic ov_t f_aluwb(input logic [1:0] rd);
    ov_t o = '0;
    o.st = 4'd8; o.rw = 1'b1; o.regdst = rd;
    return o;
  endfunction
  function automatic ov_t f_branch(input logic pcw);
    ov_t o = '0;
    o.st = 4'd9; o.asa = 1'b1; o.aluop = 4'b0001; o.pcsrc = 2'b01; o.pcw = pcw;
    return o;
  endfunction
  function automatic ov_t f_jump(input logic jal);
    ov_t o = '0;
    o.st = 4'd10; o.pcw = 1'b1; o.pcsrc = 2'b10; o.rw = jal;
    o.regdst = jal ? 2'b10 : 2'b00; o.m2r = jal ? 3'b010 : 3'b000;
    return o;
  endfunction
  function automatic ov_t f_jreg();
    ov_t o = '0;
    o.st = 4'd11; o.pcw = 1'b1; o.pcsrc = 2'b11;
    return o;
  endfunction

  task automatic push(input string tag, input ov_t v, input logic rdy, input logic z, input logic rst);
    ent_t e;
    e.tag = tag; e.v = v; e.rdy = rdy; e.z = z; e.rst = rst;
    sb.push_back(e);
  endtask
  task automatic drain();
    ent_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.rdy; zero = e.z;
      @(negedge clk);
      checks++;
      if (dv !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.tag, dv, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 6'b100011; funct = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (dv !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", dv); end
    checks++;
    if (hv !== '0) begin errors++; $display("FAIL reset_out_hold: got %h expected 0", hv); end
    @(posedge clk); #1;
  endtask
  task automatic test_pc_hold();
    reset = 1'b0; opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (h_MemRead !== 1'b1 || h_PCWrite !== 1'b0) begin
      errors++; $display("FAIL hold_first_fetch: MemRead=%b PCWrite=%b expected 1 0", h_MemRead, h_PCWrite);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (h_PCWrite !== 1'b0 || h_IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      errors++; $display("FAIL hold_ready: hold PCWrite=%b IRWrite=%b plain PCWrite=%b expected 0 1 1", h_PCWrite, h_IRWrite, PCWrite);
    end
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (h_state !== 4'd0 || h_PCWrite !== 1'b1) begin
      errors++; $display("FAIL hold_second_fetch: state=%0d PCWrite=%b expected 0 1", h_state, h_PCWrite);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task automatic test_add();
    opcode = 6'b000000; funct = 6'b100000;
    push("add_fetch", f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
    push("add_decode", f_decode(1'b0), 1'b1, 1'b0, 1'b0);
    push("add_exec", f_execr(), 1'b1, 1'b0, 1'b0);
    push("add_wb", f_aluwb(2'b01), 1'b1, 1'b0, 1'b0);
    drain();
  endtask
  task automatic test_lw();
    opcode = 6'b100011; funct = 6'b101010;
    push("lw_fetch", f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
    push("lw_decode", f_decode(1'b0), 1'b0, 1'b0, 1'b0);
    push("lw_addr", f_memaddr(), 1'b1, 1'b0, 1'b0);
    push("lw_rd_wait0", f_memrd(), 1'b0, 1'b0, 1'b0);
    push("lw_rd_wait1", f_memrd(), 1'b0, 1'b0, 1'b0);
    push("lw_rd_done", f_memrd(), 1'b1, 1'b0, 1'b0);
    push("lw_wb", f_memwb(), 1'b0, 1'b0, 1'b0);
    drain();
  endtask
  task automatic test_sw();
    opcode = 6'b101011; funct = 6'd0;
    push("sw_fetch_wait", f_fetch(1'b0), 1'b0, 1'b0, 1'b0);
    push("sw_fetch", f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
    push("sw_decode", f_decode(1'b0), 1'b1, 1'b0, 1'b0);
    push("sw_addr", f_memaddr(), 1'b0, 1'b0, 1'b0);
    push("sw_wr", f_memwr(), 1'b1, 1'b0, 1'b0);
    drain();
  endtask
  task automatic test_branch();
    logic [5:0] ops[4] = '{6'b000100, 6'b000101, 6'b000100, 6'b000101};
    logic zs[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic tk[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      opcode = ops[i];
      push($sformatf("br%0d_fetch", i), f_fetch(1'b1), 1'b1, zs[i], 1'b0);
      push($sformatf("br%0d_decode", i), f_decode(1'b0), 1'b1, zs[i], 1'b0);
      push($sformatf("br%0d_branch", i), f_branch(tk[i]), 1'b1, zs[i], 1'b0);
      drain();
    end
  endtask
  task automatic test_jumps();
    opcode = 6'b000011;
    push("jal_fetch", f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
    push("jal_decode", f_decode(1'b0), 1'b1, 1'b0, 1'b0);
    push("jal_jump", f_jump(1'b1), 1'b1, 1'b0, 1'b0);
    drain();
    opcode = 6'b000000; funct = 6'b001000;
    push("jr_fetch", f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
    push("jr_decode", f_decode(1'b0), 1'b1, 1'b0, 1'b0);
    push("jr_jreg", f_jreg(), 1'b1, 1'b0, 1'b0);
    drain();
    opcode = 6'b000010; funct = 6'd0;
    push("j_fetch", f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
    push("j_decode", f_decode(1'b0), 1'b1, 1'b0, 1'b0);
    push("j_jump", f_jump(1'b0), 1'b1, 1'b0, 1'b0);
    drain();
  endtask
  task automatic test_itype();
    logic [5:0] ops[7] = '{6'b001101, 6'b001000, 6'b001100, 6'b001110, 6'b001010, 6'b001011, 6'b001111};
    logic [3:0] alu[7] = '{4'b0100, 4'b0000, 4'b0011, 4'b0101, 4'b0110, 4'b1000, 4'b0111};
    logic imm[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      opcode = ops[i]; funct = 6'b100000;
      push($sformatf("itype%0d_fetch", i), f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
      push($sformatf("itype%0d_decode", i), f_decode(1'b0), 1'b1, 1'b0, 1'b0);
      push($sformatf("itype%0d_exec", i), f_execi(alu[i], imm[i]), 1'b1, 1'b0, 1'b0);
      push($sformatf("itype%0d_wb", i), f_aluwb(2'b00), 1'b1, 1'b0, 1'b0);
      drain();
    end
  endtask
  task automatic test_illegal();
    logic [5:0] ops[2] = '{6'b111111, 6'b001001};
    for (int i = 0; i < 2; i++) begin
      opcode = ops[i];
      push($sformatf("ill%0d_fetch", i), f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
      push($sformatf("ill%0d_decode", i), f_decode(1'b1), 1'b1, 1'b0, 1'b0);
      push($sformatf("ill%0d_after", i), f_fetch(1'b0), 1'b0, 1'b0, 1'b0);
      drain();
    end
  endtask
  task automatic test_reset_memwr();
    opcode = 6'b101011;
    push("rmw_fetch", f_fetch(1'b1), 1'b1, 1'b0, 1'b0);
    push("rmw_decode", f_decode(1'b0), 1'b1, 1'b0, 1'b0);
    push("rmw_addr", f_memaddr(), 1'b1, 1'b0, 1'b0);
    push("rmw_wr_wait", f_memwr(), 1'b0, 1'b0, 1'b0);
    push("rmw_reset", '0, 1'b0, 1'b0, 1'b1);
    push("rmw_refetch", f_fetch(1'b0), 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_pc_hold();
    test_add();
    test_lw();
    test_sw();
    test_branch();
    test_jumps();
    test_itype();
    test_illegal();
    test_reset_memwr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
